bz_multi_clken_gen: RTL and testbench

- Parametrised multi-channel clock-enable generator; next generation of the fixed two-output 150 MHz host-core PLL wrapper.
- Runs in a single fabric clock domain.
- Produces NUM_CH divided enables and square waves, each with its own runtime-programmable divide ratio and phase offset.
- Provides a `locked` indication after a settle period; consumers gate logic on `ce_out` rather than using extra PLL outputs.

---
 rtl/bz_multi_clken_gen.sv | 177 +++++++++++++++++
 tb/tb_bz_multi_clken_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bz_multi_clken_gen.sv
// bz_multi_clken_gen: multi-channel clock-enable / square-wave generator.
// Each channel has a shadow {div, phase} written through the config port and
// copied to the active set when run rises. A settle period precedes locked.
// Optional live reload of div while locked: define BZ_CLKGEN_LIVE_RELOAD_EN.
module bz_multi_clken_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned LOCK_CYCLES = 64,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_refclk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [DIV_W-1:0]  i_cfg_div,
  input  logic [DIV_W-1:0]  i_cfg_phase,
  output logic              o_cfg_err,
  output logic [NUM_CH-1:0] o_ce_out,
  output logic [NUM_CH-1:0] o_clk_out,
  output logic              o_locked
);

  localparam int unsigned SC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSettle, StLocked} state_e;

  state_e            r_state, w_state_d;
  logic [SC_W-1:0]   r_settle;
  logic [DIV_W-1:0]  r_sh_div  [NUM_CH];
  logic [DIV_W-1:0]  r_sh_ph   [NUM_CH];
  logic [DIV_W-1:0]  r_act_div [NUM_CH];
  logic [DIV_W-1:0]  r_cnt     [NUM_CH];
  logic [DIV_W-1:0]  w_act_div_d [NUM_CH];
  logic [DIV_W-1:0]  w_cnt_d     [NUM_CH];
  logic [DIV_W:0]    w_half      [NUM_CH];
  logic [NUM_CH-1:0] w_ce_d, w_clk_d;
  logic              w_bad, w_ok, w_start, w_adv, w_unmask;

`ifdef BZ_CLKGEN_LIVE_RELOAD_EN
  logic [NUM_CH-1:0] r_pend, w_pend_d;
  logic [DIV_W-1:0]  r_pend_div   [NUM_CH];
  logic [DIV_W-1:0]  w_pend_div_d [NUM_CH];
`endif

  assign o_cfg_ready = 1'b1;
  assign w_bad    = (32'(i_cfg_ch) >= NUM_CH) ||
                    ((i_cfg_div != '0) && (i_cfg_phase >= i_cfg_div));
  assign w_ok     = i_cfg_valid & ~w_bad;
  assign w_start  = (r_state == StIdle) & i_run;
  assign w_adv    = (r_state != StIdle) & i_run;
  assign w_unmask = (r_state == StLocked) & i_run;

  // State register and settle counter
  always_ff @(posedge i_refclk) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_settle <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start)                              r_settle <= '0;
      else if ((r_state == StSettle) && i_run)  r_settle <= r_settle + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (i_run) w_state_d = StSettle;
      StSettle: begin
        if (!i_run)                                   w_state_d = StIdle;
        else if (r_settle == SC_W'(LOCK_CYCLES - 1))  w_state_d = StLocked;
      end
      StLocked: if (!i_run) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Per-channel counter, active div and pending-reload next state
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_d[i]     = r_cnt[i];
      w_act_div_d[i] = r_act_div[i];
`ifdef BZ_CLKGEN_LIVE_RELOAD_EN
      w_pend_d[i]     = r_pend[i];
      w_pend_div_d[i] = r_pend_div[i];
`endif
      if (w_start) begin
        w_act_div_d[i] = r_sh_div[i];
        w_cnt_d[i]     = (r_sh_ph[i] == '0) ? '0 : r_sh_div[i] - r_sh_ph[i];
`ifdef BZ_CLKGEN_LIVE_RELOAD_EN
        w_pend_d[i]    = 1'b0;
`endif
      end else if (w_adv && (r_act_div[i] != '0)) begin
        if (r_cnt[i] == r_act_div[i] - 1'b1) begin
          w_cnt_d[i] = '0;
`ifdef BZ_CLKGEN_LIVE_RELOAD_EN
          if (r_pend[i]) begin
            w_act_div_d[i] = r_pend_div[i];
            w_pend_d[i]    = 1'b0;
          end
`endif
        end else begin
          w_cnt_d[i] = r_cnt[i] + 1'b1;
        end
      end
`ifdef BZ_CLKGEN_LIVE_RELOAD_EN
      // A new write wins over a reload consumed on the same edge
      if (w_ok && (r_state == StLocked) && (i_cfg_ch == CH_W'(i))) begin
        w_pend_d[i]     = 1'b1;
        w_pend_div_d[i] = i_cfg_div;
      end
`endif
    end
  end

  // Shadow, active and counter registers
  always_ff @(posedge i_refclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!i_rst_n) begin
        r_sh_div[i]  <= '0;
        r_sh_ph[i]   <= '0;
        r_act_div[i] <= '0;
        r_cnt[i]     <= '0;
      end else begin
        r_act_div[i] <= w_act_div_d[i];
        r_cnt[i]     <= w_cnt_d[i];
        if (w_ok && (i_cfg_ch == CH_W'(i))) begin
          r_sh_div[i] <= i_cfg_div;
          r_sh_ph[i]  <= i_cfg_phase;
        end
      end
    end
  end

`ifdef BZ_CLKGEN_LIVE_RELOAD_EN
  // Pending live-reload registers
  always_ff @(posedge i_refclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!i_rst_n) begin
        r_pend[i]     <= 1'b0;
        r_pend_div[i] <= '0;
      end else begin
        r_pend[i]     <= w_pend_d[i];
        r_pend_div[i] <= w_pend_div_d[i];
      end
    end
  end
`endif

  // Output decode; high half is ceil(div/2) computed one bit wider
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_half[i]  = ({1'b0, r_act_div[i]} + 1'b1) >> 1;
      w_ce_d[i]  = w_unmask && (r_act_div[i] != '0) && (r_cnt[i] == '0);
      w_clk_d[i] = w_unmask && (r_act_div[i] != '0) && ({1'b0, r_cnt[i]} < w_half[i]);
    end
  end

  // Registered outputs
  always_ff @(posedge i_refclk) begin
    if (!i_rst_n) begin
      o_ce_out  <= '0;
      o_clk_out <= '0;
      o_locked  <= 1'b0;
      o_cfg_err <= 1'b0;
    end else begin
      o_ce_out  <= w_ce_d;
      o_clk_out <= w_clk_d;
      o_locked  <= w_unmask;
      o_cfg_err <= i_cfg_valid & w_bad;
    end
  end

endmodule

// File: tb/tb_bz_multi_clken_gen.sv
// Bench for bz_multi_clken_gen (NUM_CH=5 so an out-of-range channel is encodable).
// The reference model predicts each output from the start cycle and the
// programmed divide/phase with modular arithmetic on the absolute cycle number.
module tb_bz_multi_clken_gen;

  localparam int NCH = 5;
  localparam int DW  = 16;
  localparam int LC  = 64;
  localparam int CHW = 3;
  localparam int INF = 32'h7fff_ffff;

  logic           clk = 1'b0;
  logic           i_rst_n = 1'b0, i_run = 1'b0, i_cfg_valid = 1'b0;
  logic [CHW-1:0] i_cfg_ch = '0;
  logic [DW-1:0]  i_cfg_div = '0, i_cfg_phase = '0;
  logic           o_cfg_ready, o_cfg_err, o_locked;
  logic [NCH-1:0] o_ce_out, o_clk_out;

  always #5 clk = ~clk;

  bz_multi_clken_gen #(.NUM_CH(NCH), .DIV_W(DW), .LOCK_CYCLES(LC)) dut (
    .i_refclk   (clk),
    .i_rst_n    (i_rst_n),
    .i_run      (i_run),
    .i_cfg_valid(i_cfg_valid),
    .o_cfg_ready(o_cfg_ready),
    .i_cfg_ch   (i_cfg_ch),
    .i_cfg_div  (i_cfg_div),
    .i_cfg_phase(i_cfg_phase),
    .o_cfg_err  (o_cfg_err),
    .o_ce_out   (o_ce_out),
    .o_clk_out  (o_clk_out),
    .o_locked   (o_locked)
  );

  int n_assert = 0, n_fail = 0, cyc = 0;
  // Model: shadow config, plus per-channel segments (div, base) where the
  // counter after edge k is (k-base) mod div; rk is the edge a reload lands.
  int sh_div [NCH], sh_ph [NCH];
  int d0 [NCH], b0 [NCH], d1 [NCH], rk [NCH];
  bit in_run = 1'b0, exp_err = 1'b0;
  int s_cyc = 0;

  function automatic int pmod(input int a, input int m);
    int r;
    r = a % m;
    return (r < 0) ? r + m : r;
  endfunction

  // Returns counter position feeding output cycle t, or -1 if outputs are masked/disabled
  function automatic int pos(input int ch, input int t);
    int k, d, b;
    k = t - 1;
    if (!in_run || t < s_cyc + LC + 1) return -1;
    if (k >= rk[ch]) begin d = d1[ch]; b = rk[ch]; end
    else             begin d = d0[ch]; b = b0[ch]; end
    if (d == 0) return -1;
    return pmod(k - b, d);
  endfunction

  function automatic int cur_div(input int ch, input int t);
    return (t - 1 >= rk[ch]) ? d1[ch] : d0[ch];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] e_ce, e_ck;
    int p, d;
    for (int c = 0; c < NCH; c++) begin
      p = pos(c, cyc);
      d = cur_div(c, cyc);
      e_ce[c] = (p == 0);
      e_ck[c] = (p >= 0) && (p < (d + 1) / 2);
    end
    chk("ce_out", 32'(o_ce_out), 32'(e_ce));
    chk("clk_out", 32'(o_clk_out), 32'(e_ck));
    chk("locked", 32'(o_locked), 32'(in_run && (cyc >= s_cyc + LC + 1)));
    chk("cfg_err", 32'(o_cfg_err), 32'(exp_err));
    chk("cfg_ready", 32'(o_cfg_ready), 32'd1);
  endtask

  // Update the model for the coming edge, take the edge, then check
  task automatic tick();
    int e, ch, dv, ph;
    bit was_run, bad;
    e = cyc + 1;
    if (!i_rst_n) begin
      in_run = 1'b0; exp_err = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        sh_div[c] = 0; sh_ph[c] = 0; rk[c] = INF;
      end
    end else begin
      was_run = in_run;
      if (!in_run && i_run) begin
        in_run = 1'b1; s_cyc = e;
        for (int c = 0; c < NCH; c++) begin
          d0[c] = sh_div[c]; rk[c] = INF; d1[c] = 0;
          b0[c] = (sh_div[c] == 0) ? e : e - pmod(sh_div[c] - sh_ph[c], sh_div[c]);
        end
      end else if (in_run && !i_run) begin
        in_run = 1'b0;
      end
      exp_err = 1'b0;
      if (i_cfg_valid) begin
        ch = int'(i_cfg_ch); dv = int'(i_cfg_div); ph = int'(i_cfg_phase);
        bad = (ch >= NCH) || (dv != 0 && ph >= dv);
        exp_err = bad;
        if (!bad) begin
          sh_div[ch] = dv; sh_ph[ch] = ph;
`ifdef BZ_CLKGEN_LIVE_RELOAD_EN
          if (was_run && i_run && (e - 1 >= s_cyc + LC)) begin
            if (rk[ch] != INF && rk[ch] > e) begin
              d1[ch] = dv;
            end else begin
              if (rk[ch] != INF) begin d0[ch] = d1[ch]; b0[ch] = rk[ch]; end
              rk[ch] = INF;
              if (d0[ch] != 0) begin
                rk[ch] = e + 1 + pmod(b0[ch] - (e + 1), d0[ch]);
                d1[ch] = dv;
              end
            end
          end
`endif
        end
      end
    end
    @(posedge clk);
    #1;
    cyc = e;
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int ch, input int dv, input int ph);
    i_cfg_valid = 1'b1;
    i_cfg_ch    = CHW'(ch);
    i_cfg_div   = DW'(dv);
    i_cfg_phase = DW'(ph);
    tick();
    i_cfg_valid = 1'b0;
  endtask

  initial begin
    int dv, ph;
    // Reset with run low
    i_rst_n = 1'b0; i_run = 1'b0;
    ticks(3);
    i_rst_n = 1'b1;
    ticks(2);

    // Start with no configuration: lock timing only, outputs stay 0
    i_run = 1'b1;
    ticks(LC + 6);
    i_run = 1'b0;
    ticks(3);

    // Directed phase relationships
    wr(0, 4, 0); wr(1, 4, 1); wr(2, 3, 0); wr(3, 1, 0);
    i_run = 1'b1;
    ticks(LC + 20);
    i_run = 1'b0;
    ticks(2);

    // Rejected writes leave shadows untouched
    wr(5, 4, 0);
    wr(0, 4, 4);
    wr(7, 0, 0);
    ticks(2);
    i_run = 1'b1;
    ticks(LC + 12);
    // Drop run mid-LOCKED and restart right away
    i_run = 1'b0;
    tick();
    i_run = 1'b1;
    ticks(LC + 12);
    i_run = 1'b0;
    ticks(2);

    // Write landing in the start cycle goes to the shadow only
    i_run = 1'b1;
    wr(0, 8, 0);
    ticks(LC + 16);
    i_run = 1'b0;
    ticks(2);
    i_run = 1'b1;
    ticks(LC + 18);
    i_run = 1'b0;
    ticks(2);

    // Write while locked: live reload if enabled, shadow-only otherwise
    wr(0, 4, 0);
    i_run = 1'b1;
    ticks(LC + 6);
    wr(0, 6, 0);
    ticks(3);
    wr(1, 5, 0);
    ticks(2);
    wr(1, 7, 0);
    ticks(25);
    i_run = 1'b0;
    ticks(2);
    i_run = 1'b1;
    ticks(LC + 14);
    i_run = 1'b0;
    ticks(2);

    // Randomised rounds, including bad writes, locked writes and a mid-run reset
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < NCH; c++) begin
        dv = int'($urandom_range(0, 9));
        ph = (dv == 0) ? 0 : int'($urandom_range(0, dv - 1));
        wr(c, dv, ph);
      end
      if ($urandom_range(0, 1) == 1) begin
        dv = int'($urandom_range(1, 9));
        wr(int'($urandom_range(0, NCH - 1)), dv, dv + int'($urandom_range(0, 3)));
      end
      i_run = 1'b1;
      ticks(LC + int'($urandom_range(4, 20)));
      dv = int'($urandom_range(0, 9));
      wr(int'($urandom_range(0, 7)), dv, 0);
      ticks(int'($urandom_range(5, 25)));
      if (r == 5) begin
        i_rst_n = 1'b0;
        ticks(2);
        i_rst_n = 1'b1;
        ticks(2);
      end
      i_run = 1'b0;
      ticks(int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
